showcase_sequencer: RTL and testbench
=====================================

# showcase_sequencer

Autonomous controller for the dice / traffic-light display. It generates the `sel` and `button` inputs of the display top level and time-slices the shared 3-bit `result` bus between the traffic lights and the dice. It runs a programmable number of rounds of "show lights, roll dice, show throw". It captures each settled throw into a register with a one-cycle valid pulse for downstream logic.

## Interface
- `LIGHTS_DWELL`, 16, cycles with `sel`=1 (lights shown) per round; must be ≥1
- `ROLL_CYCLES`, 8, cycles `button` is held high per roll; must be ≥1
- `DICE_DWELL`, 16, cycles the captured throw is shown (`sel`=0) per round; must be ≥1
- `CNT_W`, 16, width of the internal dwell counter; each dwell parameter must be < 2^CNT_W
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; begins a sequence when idle
- `stop`  in  1  level; aborts any sequence
- `rounds`  in  4  rounds per sequence, sampled on accepted `start`; 0 = run until `stop`
- `result`  in  3  display bus returned from the top level (dice value when `sel`=0)
- `sel`  out  1  mux select to top level: 0 = dice, 1 = lights
- `button`  out  1  roll request to the dice
- `busy`  out  1  high whenever state ≠ IDLE
- `dice_value`  out  3  last valid captured throw
- `dice_valid`  out  1  one-cycle pulse when `dice_value` updates
- `dice_err`  out  1  one-cycle pulse when a throw outside 1..6 is sampled

## Operation
- All outputs are registered. State machine: IDLE → LIGHTS → ROLL → SETTLE → DICE → (LIGHTS or IDLE).
- IDLE: `sel`=1, `button`=0, `busy`=0. When `start`=1 and `stop`=0, load the round counter from `rounds` and go to LIGHTS. While not IDLE, `start` is ignored.
- LIGHTS: `sel`=1, `button`=0 for exactly `LIGHTS_DWELL` cycles, then go to ROLL.
- ROLL: `sel`=0, `button`=1 for exactly `ROLL_CYCLES` cycles, then go to SETTLE.
- SETTLE: `sel`=0, `button`=0 for exactly 1 cycle. At the closing edge, sample `result`:
  - If the value is 1..6: load `dice_value` and pulse `dice_valid`.
  - If the value is 0 or 7: `dice_value` is unchanged and `dice_err` pulses.
- DICE: `sel`=0, `button`=0 for exactly `DICE_DWELL` cycles. At the end:
  - Decrement the round counter if nonzero.
  - Go to IDLE if the count has reached 0 and `rounds` was nonzero; otherwise go to LIGHTS.
- `stop`=1 in any state: the next state is IDLE and `button` drops at that edge. A capture scheduled for the same edge is suppressed.
- `start` and `stop` high together in IDLE: `stop` wins and the block stays IDLE.
- `rounds` = 0 loops indefinitely. The round counter does not wrap.
- The dwell counter restarts at 0 on every state entry.

## Timing
- Reset values: state IDLE, `sel`=1, `button`=0, `busy`=0, `dice_value`=3'd1, `dice_valid`=0, `dice_err`=0, counters 0. SIXES_CNT (when compiled in) resets to 0.
- Edge numbering: `start` is sampled at edge 0, so cycle 1 is the first cycle in LIGHTS.
- One round lasts LIGHTS_DWELL + ROLL_CYCLES + 1 + DICE_DWELL cycles.
- `dice_valid` / `dice_err` are high in the first DICE cycle, which is cycle LIGHTS_DWELL + ROLL_CYCLES + 2.
- `busy` is high from cycle 1 to the last DICE cycle of the last round inclusive.
- Reset asserted mid-sequence returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `SEQ_SIXES_EN` defined:
  - Adds output `sixes`, 8 bits, reset 0.
  - Increments on every `dice_valid` with `dice_value`=6.
  - Saturates at 255.
  - Cleared on an accepted `start`.
- `SEQ_SIXES_EN` undefined: no `sixes` port and no counter logic. All other behaviour is identical.

## Test plan
- Params 4/3/2, `rounds`=1, `result` forced to 5 when `sel`=0:
  - `start` at edge 0 → `sel`=1 in cycles 1–4, `button`=1 in cycles 5–7, SETTLE in cycle 8.
  - `dice_valid`=1 and `dice_value`=5 in cycle 9, DICE in cycles 9–10, `busy`=0 from cycle 11.
- `rounds`=3 → exactly 3 `dice_valid` pulses spaced 10 cycles apart, then IDLE.
- `rounds`=0 → rounds repeat indefinitely; assert `stop` in cycle 6 (ROLL) → `button`=0 and IDLE from cycle 7, with no `dice_valid`.
- `result`=7 during SETTLE → `dice_err` pulses and `dice_value` keeps its prior value of 5.
- `start` in cycle 3 while busy is ignored, so the round timing is unchanged. `start`+`stop` together in IDLE → stays IDLE.
- `rst` pulsed high mid-DICE → outputs return to reset values asynchronously. With `SEQ_SIXES_EN` defined and `result`=6 for 3 rounds → `sixes`=3.

Source files
------------

// File: rtl/showcase_sequencer.sv
// Round sequencer for the dice / traffic-light display: lights, roll, settle, show throw.
// Optional saturating six counter on output o_sixes when SEQ_SIXES_EN is defined.
module showcase_sequencer #(
    parameter int LIGHTS_DWELL = 16,
    parameter int ROLL_CYCLES  = 8,
    parameter int DICE_DWELL   = 16,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [3:0] i_rounds,
    input  logic [2:0] i_result,
    output logic       o_sel,
    output logic       o_button,
    output logic       o_busy,
    output logic [2:0] o_dice_value,
    output logic       o_dice_valid,
`ifdef SEQ_SIXES_EN
    output logic       o_dice_err,
    output logic [7:0] o_sixes
`else
    output logic       o_dice_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_ROLL   = 3'd2,
        S_SETTLE = 3'd3,
        S_DICE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] L_LIGHTS_LAST = CNT_W'(LIGHTS_DWELL - 1);
    localparam logic [CNT_W-1:0] L_ROLL_LAST   = CNT_W'(ROLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_DICE_LAST   = CNT_W'(DICE_DWELL - 1);

    function automatic logic f_throw_ok(input logic [2:0] v);
        f_throw_ok = (v >= 3'd1) && (v <= 3'd6);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_round;
    logic [3:0]       w_round_next;
    logic             w_start_accept;

    logic             w_sel;
    logic             w_button;
    logic             w_busy;
    logic             w_capture;
    logic             w_valid;
    logic             w_err;

    logic             r_sel;
    logic             r_button;
    logic             r_busy;
    logic [2:0]       r_dice_value;
    logic             r_dice_valid;
    logic             r_dice_err;

    // State, dwell counter and round counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_round <= w_round_next;
        end
    end

    // Next-state logic; stop overrides every transition
    always_comb begin
        w_next         = r_state;
        w_round_next   = r_round;
        w_start_accept = 1'b0;
        if (i_stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_next         = S_LIGHTS;
                        w_round_next   = i_rounds;
                        w_start_accept = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_LIGHTS: begin
                    if (r_cnt == L_LIGHTS_LAST) begin
                        w_next = S_ROLL;
                    end else begin
                        w_next = S_LIGHTS;
                    end
                end
                S_ROLL: begin
                    if (r_cnt == L_ROLL_LAST) begin
                        w_next = S_SETTLE;
                    end else begin
                        w_next = S_ROLL;
                    end
                end
                S_SETTLE: begin
                    w_next = S_DICE;
                end
                S_DICE: begin
                    if (r_cnt == L_DICE_LAST) begin
                        // A zero count means endless mode; it never decrements or ends the sequence.
                        if (r_round != 4'd0) begin
                            w_round_next = r_round - 4'd1;
                        end else begin
                            w_round_next = r_round;
                        end
                        if (r_round == 4'd1) begin
                            w_next = S_IDLE;
                        end else begin
                            w_next = S_LIGHTS;
                        end
                    end else begin
                        w_next = S_DICE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_sel      = 1'b1;
        w_button   = 1'b0;
        w_busy     = 1'b0;
        w_capture  = 1'b0;
        w_valid    = 1'b0;
        w_err      = 1'b0;
        w_cnt_next = '0;
        if ((w_next != r_state) || (w_next == S_IDLE)) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        case (w_next)
            S_IDLE:   begin w_sel = 1'b1; w_button = 1'b0; w_busy = 1'b0; end
            S_LIGHTS: begin w_sel = 1'b1; w_button = 1'b0; w_busy = 1'b1; end
            S_ROLL:   begin w_sel = 1'b0; w_button = 1'b1; w_busy = 1'b1; end
            S_SETTLE: begin w_sel = 1'b0; w_button = 1'b0; w_busy = 1'b1; end
            S_DICE:   begin w_sel = 1'b0; w_button = 1'b0; w_busy = 1'b1; end
            default:  begin w_sel = 1'b1; w_button = 1'b0; w_busy = 1'b0; end
        endcase
        // SETTLE lasts one cycle, so being in it means this edge closes it.
        w_capture = (r_state == S_SETTLE) && !i_stop;
        if (w_capture) begin
            w_valid = f_throw_ok(i_result);
            w_err   = !f_throw_ok(i_result);
        end else begin
            w_valid = 1'b0;
            w_err   = 1'b0;
        end
    end

    // Registered outputs and throw capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel        <= 1'b1;
            r_button     <= 1'b0;
            r_busy       <= 1'b0;
            r_dice_value <= 3'd1;
            r_dice_valid <= 1'b0;
            r_dice_err   <= 1'b0;
        end else begin
            r_sel        <= w_sel;
            r_button     <= w_button;
            r_busy       <= w_busy;
            r_dice_valid <= w_valid;
            r_dice_err   <= w_err;
            if (w_valid) begin
                r_dice_value <= i_result;
            end else begin
                r_dice_value <= r_dice_value;
            end
        end
    end

    assign o_sel        = r_sel;
    assign o_button     = r_button;
    assign o_busy       = r_busy;
    assign o_dice_value = r_dice_value;
    assign o_dice_valid = r_dice_valid;
    assign o_dice_err   = r_dice_err;

`ifdef SEQ_SIXES_EN
    logic [7:0] r_sixes;

    // Saturating count of captured sixes, cleared when a new sequence starts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sixes <= 8'd0;
        end else if (w_start_accept) begin
            r_sixes <= 8'd0;
        end else if (w_valid && (i_result == 3'd6) && (r_sixes != 8'hFF)) begin
            r_sixes <= r_sixes + 8'd1;
        end else begin
            r_sixes <= r_sixes;
        end
    end

    assign o_sixes = r_sixes;
`else
    logic w_unused;
    assign w_unused = w_start_accept;
`endif

endmodule

// File: tb/tb_showcase_sequencer.sv
// Self-checking bench for showcase_sequencer using a round-position reference model.
// Define SEQ_SIXES_EN to also check the six counter.
module tb_showcase_sequencer;

    localparam int LD        = 4;
    localparam int RC        = 3;
    localparam int DD        = 2;
    localparam int ROUND_LEN = LD + RC + 1 + DD;
    localparam int SETTLE_AT = LD + RC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] rounds;
    logic [2:0] result;
    logic       o_sel;
    logic       o_button;
    logic       o_busy;
    logic [2:0] o_dice_value;
    logic       o_dice_valid;
    logic       o_dice_err;
`ifdef SEQ_SIXES_EN
    logic [7:0] o_sixes;
`endif

    always #5 clk = ~clk;

    showcase_sequencer #(
        .LIGHTS_DWELL(LD),
        .ROLL_CYCLES (RC),
        .DICE_DWELL  (DD),
        .CNT_W       (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_rounds    (rounds),
        .i_result    (result),
        .o_sel       (o_sel),
        .o_button    (o_button),
        .o_busy      (o_busy),
        .o_dice_value(o_dice_value),
        .o_dice_valid(o_dice_valid),
`ifdef SEQ_SIXES_EN
        .o_dice_err  (o_dice_err),
        .o_sixes     (o_sixes)
`else
        .o_dice_err  (o_dice_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current round (1..ROUND_LEN) and rounds left
    bit       m_active;
    int       m_pos;
    int       m_left;
    bit       m_inf;
    logic [2:0] m_value;
    bit       m_valid;
    bit       m_err;
    int       m_sixes;
    int       cyc;
    int       valid_cycles[$];
    int       err_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_left   = 0;
        m_inf    = 1'b0;
        m_value  = 3'd1;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_sixes  = 0;
    endtask

    task automatic model_edge();
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_pos    = 1;
                m_left   = int'(rounds);
                m_inf    = (rounds == 4'd0);
                m_sixes  = 0;
            end
        end else begin
            if (m_pos == SETTLE_AT) begin
                if (result >= 3'd1 && result <= 3'd6) begin
                    m_value = result;
                    m_valid = 1'b1;
                    if (result == 3'd6 && m_sixes < 255) m_sixes++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_pos == ROUND_LEN) begin
                if (!m_inf) m_left--;
                if (!m_inf && m_left == 0) m_active = 1'b0;
                else m_pos = 1;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        bit e_sel;
        bit e_button;
        e_sel    = !m_active || (m_pos <= LD);
        e_button = m_active && (m_pos > LD) && (m_pos <= LD + RC);
        chk({tag, "_sel"},    32'(o_sel),        32'(e_sel));
        chk({tag, "_button"}, 32'(o_button),     32'(e_button));
        chk({tag, "_busy"},   32'(o_busy),       32'(m_active));
        chk({tag, "_value"},  32'(o_dice_value), 32'(m_value));
        chk({tag, "_valid"},  32'(o_dice_valid), 32'(m_valid));
        chk({tag, "_err"},    32'(o_dice_err),   32'(m_err));
`ifdef SEQ_SIXES_EN
        chk({tag, "_sixes"},  32'(o_sixes),      32'(m_sixes));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs(tag);
        if (o_dice_valid) valid_cycles.push_back(cyc);
        if (o_dice_err) err_count++;
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        rounds = 4'd0;
        result = 3'd0;
        model_reset();
        cyc       = 0;
        err_count = 0;
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step("idle");
        step("idle");

        // Single round, throw 5
        result = 3'd5; rounds = 4'd1; start = 1'b1;
        cyc = 0; valid_cycles.delete();
        step("one");
        start = 1'b0;
        repeat (11) step("one");
        chk("one_valid_count", 32'(valid_cycles.size()), 32'd1);
        if (valid_cycles.size() == 1) chk("one_valid_cycle", 32'(valid_cycles[0]), 32'd9);
        chk("one_value", 32'(o_dice_value), 32'd5);
        chk("one_idle", 32'(o_busy), 32'd0);

        // Three rounds with random legal throws
        rounds = 4'd3; start = 1'b1;
        cyc = 0; valid_cycles.delete();
        step("three");
        start = 1'b0;
        repeat (34) begin
            result = 3'($urandom_range(1, 6));
            step("three");
        end
        chk("three_count", 32'(valid_cycles.size()), 32'd3);
        if (valid_cycles.size() == 3) begin
            chk("three_gap1", 32'(valid_cycles[1] - valid_cycles[0]), 32'(ROUND_LEN));
            chk("three_gap2", 32'(valid_cycles[2] - valid_cycles[1]), 32'(ROUND_LEN));
        end

        // Endless mode, then stop during ROLL
        rounds = 4'd0; start = 1'b1;
        step("loop");
        start = 1'b0;
        repeat (25) begin
            result = 3'($urandom_range(0, 7));
            step("loop");
        end
        guard = 0;
        while (!(m_active && m_pos > LD && m_pos <= LD + RC) && guard < 30) begin
            step("loop");
            guard++;
        end
        chk("loop_reach_roll", 32'(guard < 30), 32'd1);
        stop = 1'b1;
        valid_cycles.delete();
        step("loop_stop");
        stop = 1'b0;
        chk("loop_stop_button", 32'(o_button), 32'd0);
        chk("loop_stop_busy", 32'(o_busy), 32'd0);
        repeat (12) step("loop_after");
        chk("loop_no_valid", 32'(valid_cycles.size()), 32'd0);

        // Illegal throw keeps the previous value
        result = 3'd5; rounds = 4'd1; start = 1'b1;
        step("bad");
        start = 1'b0;
        repeat (11) step("bad");
        result = 3'd7; start = 1'b1; err_count = 0;
        step("bad");
        start = 1'b0;
        repeat (11) step("bad");
        chk("bad_err_count", 32'(err_count), 32'd1);
        chk("bad_value_kept", 32'(o_dice_value), 32'd5);

        // Start while busy is ignored; start with stop in idle stays idle
        result = 3'd4; rounds = 4'd1; start = 1'b1;
        cyc = 0; valid_cycles.delete();
        step("busy_start");
        start = 1'b0;
        step("busy_start");
        step("busy_start");
        start = 1'b1;
        step("busy_start");
        start = 1'b0;
        repeat (8) step("busy_start");
        chk("busy_start_count", 32'(valid_cycles.size()), 32'd1);
        if (valid_cycles.size() == 1) chk("busy_start_cycle", 32'(valid_cycles[0]), 32'd9);
        start = 1'b1; stop = 1'b1;
        step("start_stop");
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", 32'(o_busy), 32'd0);

        // Random start/stop/rounds/result traffic
        repeat (300) begin
            start  = ($urandom_range(0, 9) == 0);
            stop   = ($urandom_range(0, 49) == 0);
            rounds = 4'($urandom_range(0, 3));
            result = 3'($urandom_range(0, 7));
            step("rand");
        end
        start = 1'b0; stop = 1'b1;
        step("rand_end");
        stop = 1'b0;

        // Asynchronous reset in the middle of DICE
        result = 3'd2; rounds = 4'd1; start = 1'b1;
        cyc = 0;
        step("arst");
        start = 1'b0;
        repeat (8) step("arst");
        chk("arst_in_dice", 32'(m_active && m_pos == SETTLE_AT + 1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst_async");
        @(negedge clk);
        rst = 1'b0;
        step("arst_after");

        // Three sixes
        result = 3'd6; rounds = 4'd3; start = 1'b1;
        step("six");
        start = 1'b0;
        repeat (34) step("six");
`ifdef SEQ_SIXES_EN
        chk("six_total", 32'(o_sixes), 32'd3);
`endif
        chk("six_value", 32'(o_dice_value), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
